dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the single-ported 64x32 data memory.
- Requester 0 is the CPU load/store port; requester 1 is the debug/loader port used to preload or inspect data memory.
- Serializes accesses with round-robin fairness and drives the memory's write-enable, address and write-data inputs.
- Samples the memory's asynchronous read data into a registered response.

---
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a single-ported data memory.
// Each access takes IDLE -> BUSY (memory cycle, grant) -> DONE (read response).
module dmem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_reg;
  logic                ptr_reg;
  logic                owner_reg;
  logic                we_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [1:0]          gnt_reg;
  logic [1:0]          rvalid_reg;
  logic                mem_write_reg;

  logic [1:0]          req_vec;
  logic [1:0]          we_vec;
  logic [ADDR_W-1:0]   addr_vec  [2];
  logic [DATA_W-1:0]   wdata_vec [2];
  logic                winner;

  assign req_vec      = {r1_req, r0_req};
  assign we_vec       = {r1_we, r0_we};
  assign addr_vec[0]  = r0_addr;
  assign addr_vec[1]  = r1_addr;
  assign wdata_vec[0] = r0_wdata;
  assign wdata_vec[1] = r1_wdata;

  // Contested requests go to the pointer; otherwise the lone requester wins.
  always_comb begin
    winner = req_vec[1];
    if (req_vec == 2'b11) begin
      winner = ptr_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= 1'b0;
      owner_reg     <= 1'b0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      gnt_reg       <= 2'b00;
      rvalid_reg    <= 2'b00;
      mem_write_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          rvalid_reg <= 2'b00;
          if (|req_vec) begin
            owner_reg     <= winner;
            we_reg        <= we_vec[winner];
            addr_reg      <= addr_vec[winner];
            wdata_reg     <= wdata_vec[winner];
            ptr_reg       <= ~winner;
            gnt_reg       <= {winner, ~winner};
            mem_write_reg <= we_vec[winner];
            state_reg     <= BUSY;
          end
        end
        BUSY: begin
          gnt_reg       <= 2'b00;
          mem_write_reg <= 1'b0;
          rvalid_reg    <= we_reg ? 2'b00 : {owner_reg, ~owner_reg};
          state_reg     <= DONE;
        end
        DONE: begin
          rvalid_reg <= 2'b00;
          state_reg  <= IDLE;
        end
        default: begin
          gnt_reg       <= 2'b00;
          rvalid_reg    <= 2'b00;
          mem_write_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  // Per-requester read-data holding registers; only the owner's own read updates it.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [DATA_W-1:0] rdata_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_reg <= '0;
      end else if (state_reg == BUSY && !we_reg && owner_reg == 1'(gi)) begin
        rdata_reg <= mem_read_data;
      end
    end
  end

  assign r0_gnt         = gnt_reg[0];
  assign r1_gnt         = gnt_reg[1];
  assign r0_rvalid      = rvalid_reg[0];
  assign r1_rvalid      = rvalid_reg[1];
  assign r0_rdata       = g_rd[0].rdata_reg;
  assign r1_rdata       = g_rd[1].rdata_reg;
  assign mem_write      = mem_write_reg;
  assign mem_address    = addr_reg;
  assign mem_write_data = wdata_reg;
  assign busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: memory model, transaction-window reference model,
// per-cycle compare process and directed scenarios with literal expectations.
module tb_dmem_arbiter;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              r0_req = 1'b0, r0_we = 1'b0;
  logic [ADDR_W-1:0] r0_addr = '0;
  logic [DATA_W-1:0] r0_wdata = '0;
  logic              r1_req = 1'b0, r1_we = 1'b0;
  logic [ADDR_W-1:0] r1_addr = '0;
  logic [DATA_W-1:0] r1_wdata = '0;
  logic              r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [DATA_W-1:0] r0_rdata, r1_rdata;
  logic              mem_write, busy;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data, mem_read_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .busy(busy)
  );

  // Environment memory: combinational read, write on the rising edge.
  logic [DATA_W-1:0] tb_mem [64];
  initial for (int i = 0; i < 64; i++) tb_mem[i] = 32'hA5A5_0000 | i;
  always @(posedge clk) if (mem_write) tb_mem[mem_address] = mem_write_data;
  assign mem_read_data = tb_mem[mem_address];

  // Reference model: each access is a window [arb edge, arb edge + 2].
  int                cyc = 0;
  int                arb_cyc = -100;
  logic              m_valid = 1'b0, m_ptr = 1'b0, m_owner = 1'b0, m_we = 1'b0, w;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  logic [DATA_W-1:0] ref_mem [64];
  logic [DATA_W-1:0] exp_rdata [2] = '{32'h0, 32'h0};
  initial for (int i = 0; i < 64; i++) ref_mem[i] = 32'hA5A5_0000 + i;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0; m_ptr = 1'b0; m_owner = 1'b0; m_we = 1'b0;
      m_addr = '0; m_wdata = '0;
      exp_rdata[0] = '0; exp_rdata[1] = '0;
    end else begin
      cyc++;
      if (m_valid && cyc == arb_cyc + 1) begin
        if (m_we) ref_mem[m_addr] = m_wdata;
        else      exp_rdata[m_owner] = ref_mem[m_addr];
      end
      if ((!m_valid || cyc >= arb_cyc + 3) && (r0_req || r1_req)) begin
        w       = (r0_req && r1_req) ? m_ptr : r1_req;
        m_owner = w;
        m_we    = w ? r1_we : r0_we;
        m_addr  = w ? r1_addr : r0_addr;
        m_wdata = w ? r1_wdata : r0_wdata;
        m_ptr   = !w;
        m_valid = 1'b1;
        arb_cyc = cyc;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("gnt0",   r0_gnt,    32'(m_valid && cyc == arb_cyc && !m_owner));
      chk("gnt1",   r1_gnt,    32'(m_valid && cyc == arb_cyc && m_owner));
      chk("rvalid0", r0_rvalid, 32'(m_valid && cyc == arb_cyc + 1 && !m_we && !m_owner));
      chk("rvalid1", r1_rvalid, 32'(m_valid && cyc == arb_cyc + 1 && !m_we && m_owner));
      chk("mem_write", mem_write, 32'(m_valid && cyc == arb_cyc && m_we));
      chk("busy", busy, 32'(m_valid && (cyc == arb_cyc || cyc == arb_cyc + 1)));
      chk("mem_address", 32'(mem_address), 32'(m_addr));
      chk("mem_write_data", mem_write_data, m_wdata);
      chk("rdata0", r0_rdata, exp_rdata[0]);
      chk("rdata1", r1_rdata, exp_rdata[1]);
    end
  end

  task automatic wait_gnt(output int who, output int at);
    who = -1;
    at  = -1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (r0_gnt || r1_gnt) begin
        who = r1_gnt ? 1 : 0;
        at  = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_gnt: no grant within 8 cycles (cycle %0d)", cyc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int who, at, prev, t0;

  initial begin
    // Reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_gnt", {r1_gnt, r0_gnt}, 0);
    chk("rst_rvalid", {r1_rvalid, r0_rvalid}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_address", 32'(mem_address), 0);
    chk("rst_rdata0", r0_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // r0 write 0xDEADBEEF to address 5
    @(negedge clk);
    t0 = cyc;
    r0_req = 1; r0_we = 1; r0_addr = 5; r0_wdata = 32'hDEADBEEF;
    wait_gnt(who, at);
    chk("wr_owner", who, 0);
    chk("wr_gnt_latency", at - t0, 1);
    chk("wr_mem_write", mem_write, 1);
    chk("wr_mem_address", 32'(mem_address), 5);
    @(negedge clk);
    r0_req = 0;
    @(posedge clk); #1;
    chk("wr_mem_write_done", mem_write, 0);
    chk("wr_no_rvalid", r0_rvalid, 0);

    // r0 read address 5
    @(negedge clk);
    r0_req = 1; r0_we = 0; r0_addr = 5;
    wait_gnt(who, at);
    chk("rd_owner", who, 0);
    @(negedge clk);
    r0_req = 0;
    @(posedge clk); #1;
    chk("rd_rvalid0", r0_rvalid, 1);
    chk("rd_rdata0", r0_rdata, 32'hDEADBEEF);
    chk("rd_rdata1_untouched", r1_rdata, 0);

    // Both requesting continuously: alternating grants every 3 cycles
    do_reset();
    r0_req = 1; r0_we = 0; r0_addr = 1;
    r1_req = 1; r1_we = 0; r1_addr = 2;
    prev = -1;
    for (int g = 0; g < 8; g++) begin
      wait_gnt(who, at);
      chk("rr_owner", who, g % 2);
      if (g > 0) chk("rr_spacing", at - prev, 3);
      prev = at;
    end
    @(negedge clk);
    r0_req = 0; r1_req = 0;
    repeat (3) @(posedge clk); #1;
    chk("rr_rdata0", r0_rdata, 32'hA5A5_0001);
    chk("rr_rdata1", r1_rdata, 32'hA5A5_0002);

    // r1 alone, then r0 joins right after an r1 grant
    repeat (2) @(negedge clk);
    r1_req = 1; r1_we = 0; r1_addr = 3;
    prev = -1;
    for (int g = 0; g < 3; g++) begin
      wait_gnt(who, at);
      chk("solo_owner", who, 1);
      if (g > 0) chk("solo_spacing", at - prev, 3);
      prev = at;
    end
    @(negedge clk);
    r0_req = 1; r0_we = 0; r0_addr = 4;
    wait_gnt(who, at);
    chk("join_owner", who, 0);
    chk("join_spacing", at - prev, 3);
    @(negedge clk);
    r0_req = 0; r1_req = 0;

    // Command captured at arbitration only
    repeat (3) @(negedge clk);
    r1_req = 1; r1_we = 0; r1_addr = 7;
    wait_gnt(who, at);
    chk("cap_owner", who, 1);
    chk("cap_addr", 32'(mem_address), 7);
    @(negedge clk);
    r1_addr = 9;
    @(posedge clk); #1;
    chk("cap_rvalid1", r1_rvalid, 1);
    chk("cap_rdata1", r1_rdata, 32'hA5A5_0007);
    prev = at;
    wait_gnt(who, at);
    chk("cap2_owner", who, 1);
    chk("cap2_addr", 32'(mem_address), 9);
    chk("cap2_spacing", at - prev, 3);
    @(negedge clk);
    r1_req = 0;
    @(posedge clk); #1;
    chk("cap2_rdata1", r1_rdata, 32'hA5A5_0009);

    // Reset during BUSY of a write
    repeat (3) @(negedge clk);
    r0_req = 1; r0_we = 1; r0_addr = 10; r0_wdata = 32'h12345678;
    wait_gnt(who, at);
    chk("rbw_owner", who, 0);
    chk("rbw_mem_write", mem_write, 1);
    @(negedge clk);
    rst_n = 0;
    r0_req = 0;
    #1;
    chk("rbw_mem_write_drop", mem_write, 0);
    chk("rbw_gnt_drop", r0_gnt, 0);
    chk("rbw_busy_drop", busy, 0);
    @(posedge clk); #1;
    chk("rbw_no_rvalid", r0_rvalid, 0);
    chk("rbw_no_write", mem_write, 0);
    @(negedge clk);
    rst_n = 1;
    r0_req = 1; r0_we = 0; r0_addr = 10;
    r1_req = 1; r1_we = 0; r1_addr = 11;
    wait_gnt(who, at);
    chk("rbw_contested_owner", who, 0);
    @(negedge clk);
    r0_req = 0; r1_req = 0;
    @(posedge clk); #1;
    chk("rbw_rvalid0", r0_rvalid, 1);
    chk("rbw_rdata0_unwritten", r0_rdata, 32'hA5A5_000A);

    repeat (4) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
